uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle of uart_tx_fifo: push port, FIFO status flags and serial line.
interface uart_tx_fifo_if;
    logic       wr_en;
    logic [7:0] din;
    logic       fifo_full;
    logic       fifo_almost_full;
    logic       fifo_empty;
    logic       overflow;
    logic       tx;
    logic       tx_busy;

    modport master (
        output wr_en, din,
        input  fifo_full, fifo_almost_full, fifo_empty, overflow, tx, tx_busy
    );

    modport slave (
        input  wr_en, din,
        output fifo_full, fifo_almost_full, fifo_empty, overflow, tx, tx_busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1, LSB first, one bit every CLK_FREQ/UART_BAUD clocks.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BAUD  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk_50m,
    input  logic          reset_n,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLK_FREQ / UART_BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(FIFO_DEPTH - 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    rd_data_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, afull_q, empty_q, overflow_q;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_done;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // A write while full is dropped even when the FSM pops in the same cycle.
    assign push = bus.wr_en && !full_q;

    // Storage has no reset so it maps onto block RAM; read data is registered on pop.
    always_ff @(posedge clk_50m) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
        if (pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_C);
            afull_q  <= (count_d >= AFULL_C);
            empty_q  <= (count_d == '0);
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Every line-bit state shares one free-running DIV-clock counter.
        if (state_q != S_IDLE && state_q != S_LOAD) begin
            baud_d = bit_done ? '0 : baud_q + BW'(1);
        end
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d = rd_data_q;
                tx_d    = 1'b0;
                idx_d   = '0;
                baud_d  = '0;
`ifdef UART_TX_PARITY_EN
                par_d   = ^rd_data_q;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx               = tx_q;
    assign bus.tx_busy          = (state_q != S_IDLE);
    assign bus.fifo_full        = full_q;
    assign bus.fifo_almost_full = afull_q;
    assign bus.fifo_empty       = empty_q;
    assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo at DIV=10: vector table, corner sequences, line-decoding scoreboard.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ  = 1000000;
    localparam int UART_BAUD = 100000;
    localparam int DIV       = CLK_FREQ / UART_BAUD;
    localparam int DEPTH     = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    typedef struct packed {
        logic [7:0] din;
        logic       par;
    } vec_t;

    logic       clk_50m = 1'b0;
    logic       reset_n = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] sb [$];

    uart_tx_fifo_if ser();

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BAUD (UART_BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_50m(clk_50m),
        .reset_n(reset_n),
        .bus    (ser)
    );

    always #5 clk_50m = ~clk_50m;
    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Line decoder: every bit must hold for exactly DIV samples; aborts on reset.
    task automatic rx_frame();
        logic [NB-1:0] bits;
        logic          stable;
        logic [7:0]    exp_b;
        bits   = '0;
        stable = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            if (k != 0) begin
                @(negedge clk_50m);
                if (!reset_n) return;
            end
            if (k % DIV == 0) bits[k / DIV] = ser.tx;
            else if (ser.tx !== bits[k / DIV]) stable = 1'b0;
        end
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: got frame 0x%0h, required no frame", bits);
        end else begin
            exp_b = sb.pop_front();
            $display("rx frame: line bits 0x%0h stable=%b, expected byte 0x%02h", bits, stable, exp_b);
            n_checks++;
            if ({stable, bits} !== {1'b1, frame_bits(exp_b)}) begin
                n_fail++;
                $display("FAIL rx_frame: got 0x%0h, required 0x%0h", {stable, bits}, {1'b1, frame_bits(exp_b)});
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_50m);
            if (reset_n && ser.tx === 1'b0) rx_frame();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic single_byte(input logic [7:0] b, input logic par);
        int   k;
        logic bit9;
        check1("idle_busy", ser.tx_busy, 1'b0);
        check1("idle_empty", ser.fifo_empty, 1'b1);
        sb.push_back(b);
        ser.wr_en = 1'b1;
        ser.din   = b;
        @(negedge clk_50m);
        ser.wr_en = 1'b0;
        check1("empty_after_e0", ser.fifo_empty, 1'b0);
        @(negedge clk_50m);
        check1("empty_after_e1", ser.fifo_empty, 1'b1);
        check1("busy_after_e1", ser.tx_busy, 1'b1);
        check1("tx_high_in_load", ser.tx, 1'b1);
        @(negedge clk_50m);
        check1("tx_fall_after_e2", ser.tx, 1'b0);
        k    = 0;
        bit9 = 1'bx;
        while (ser.tx_busy && k <= FRAME + 20) begin
            @(negedge clk_50m);
            k++;
            if (k == 9 * DIV + DIV / 2) bit9 = ser.tx;
        end
        check_int("busy_len", k, FRAME);
`ifdef UART_TX_PARITY_EN
        check1("parity_bit", bit9, par);
`else
        check1("stop_bit", bit9, 1'b1);
`endif
    endtask

    task automatic wait_drain(input int limit);
        int k = 0;
        while (!(ser.fifo_empty && !ser.tx_busy) && k < limit) begin
            @(negedge clk_50m);
            k++;
        end
        check1("drain_done", ser.fifo_empty && !ser.tx_busy, 1'b1);
        repeat (3) @(negedge clk_50m);
    endtask

    initial begin
        vec_t vecs [6];
        int   c0;
        vecs[0] = '{din: 8'hA5, par: 1'b0};
        vecs[1] = '{din: 8'h07, par: 1'b1};
        vecs[2] = '{din: 8'h03, par: 1'b0};
        vecs[3] = '{din: 8'h80, par: 1'b1};
        vecs[4] = '{din: 8'hFF, par: 1'b0};
        vecs[5] = '{din: 8'h01, par: 1'b1};

        ser.wr_en = 1'b0;
        ser.din   = 8'h00;
        repeat (3) @(negedge clk_50m);
        check1("rst_tx", ser.tx, 1'b1);
        check1("rst_busy", ser.tx_busy, 1'b0);
        check1("rst_empty", ser.fifo_empty, 1'b1);
        check1("rst_full", ser.fifo_full, 1'b0);
        check1("rst_afull", ser.fifo_almost_full, 1'b0);
        check1("rst_overflow", ser.overflow, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_50m);

        // Single bytes from the vector table.
        for (int i = 0; i < 6; i++) begin
            single_byte(vecs[i].din, vecs[i].par);
            repeat (2) @(negedge clk_50m);
        end

        // Three-byte burst on consecutive cycles: contiguous frames, one LOAD cycle between.
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        sb.push_back(8'h55);
        ser.wr_en = 1'b1;
        ser.din   = 8'h00;
        @(negedge clk_50m);
        c0 = cyc;
        ser.din = 8'hFF;
        @(negedge clk_50m);
        ser.din = 8'h55;
        @(negedge clk_50m);
        ser.wr_en = 1'b0;
        while (ser.tx_busy && cyc < c0 + 3 * FRAME + 30) @(negedge clk_50m);
        check_int("burst_busy_end", cyc, c0 + 2 + 3 * FRAME + 2);
        wait_drain(100);

        // Fill to full behind a busy frame, then one dropped write.
        sb.push_back(8'hC0);
        ser.wr_en = 1'b1;
        ser.din   = 8'hC0;
        @(negedge clk_50m);
        ser.wr_en = 1'b0;
        repeat (2) @(negedge clk_50m);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            ser.wr_en = 1'b1;
            ser.din   = 8'(8'h10 + i);
            if (i <= DEPTH) sb.push_back(8'(8'h10 + i));
            @(negedge clk_50m);
            check1($sformatf("afull_w%0d", i), ser.fifo_almost_full, i >= DEPTH - 2);
            check1($sformatf("full_w%0d", i), ser.fifo_full, i >= DEPTH);
            check1($sformatf("ovf_w%0d", i), ser.overflow, i > DEPTH);
        end
        ser.wr_en = 1'b0;
        wait_drain(3000);

        // Reset pulsed during data bit 3 of 0x96 abandons the frame.
        sb.push_back(8'h96);
        ser.wr_en = 1'b1;
        ser.din   = 8'h96;
        @(negedge clk_50m);
        c0 = cyc;
        ser.wr_en = 1'b0;
        while (cyc < c0 + 2 + 4 * DIV + DIV / 2) @(negedge clk_50m);
        check1("pre_rst_data_bit3", ser.tx, 1'b0);
        check1("pre_rst_busy", ser.tx_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("midrst_tx", ser.tx, 1'b1);
        check1("midrst_busy", ser.tx_busy, 1'b0);
        repeat (2) @(negedge clk_50m);
        reset_n = 1'b1;
        sb.delete();
        @(negedge clk_50m);
        check1("postrst_overflow", ser.overflow, 1'b0);
        check1("postrst_empty", ser.fifo_empty, 1'b1);
        check1("postrst_tx", ser.tx, 1'b1);
        single_byte(8'h3C, 1'b0);
        repeat (2) @(negedge clk_50m);

        // Write while full on the same edge as the STOP-exit pop.
        sb.push_back(8'hD0);
        ser.wr_en = 1'b1;
        ser.din   = 8'hD0;
        @(negedge clk_50m);
        c0 = cyc;
        ser.wr_en = 1'b0;
        repeat (2) @(negedge clk_50m);
        for (int i = 1; i <= DEPTH; i++) begin
            ser.wr_en = 1'b1;
            ser.din   = 8'(8'h20 + i);
            sb.push_back(8'(8'h20 + i));
            @(negedge clk_50m);
        end
        ser.wr_en = 1'b0;
        check1("fill2_full", ser.fifo_full, 1'b1);
        check1("fill2_overflow", ser.overflow, 1'b0);
        while (cyc < c0 + 1 + FRAME) @(negedge clk_50m);
        ser.wr_en = 1'b1;
        ser.din   = 8'hEE;
        @(negedge clk_50m);
        ser.wr_en = 1'b0;
        check1("popwr_overflow", ser.overflow, 1'b1);
        check1("popwr_full", ser.fifo_full, 1'b0);
        check1("popwr_afull", ser.fifo_almost_full, 1'b1);
        check1("popwr_tx_load", ser.tx, 1'b1);
        wait_drain(3000);

        check_int("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
